// File: rtl/ram_arb_n_pkg.sv
// Shared constants and helpers for the N-port Wishbone RAM arbiter.
// RAM_ARB_RR_EN selects round-robin arbitration (default: fixed priority).
package ram_arb_n_pkg;

  localparam int DEF_N     = 2;
  localparam int DEF_WIDTH = 10;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ram_arb_n_rr_pick.sv
// Rotating priority picker: first requester at or after base wins.
// Base is ignored (lowest index wins) unless RAM_ARB_RR_EN is defined.
module ram_arb_n_rr_pick
  import ram_arb_n_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_base,
  output logic [N-1:0]  o_pick,
  output logic [IW-1:0] o_idx
);

  logic [IW-1:0] w_base;

`ifdef RAM_ARB_RR_EN
  assign w_base = i_base;
`else
  assign w_base = i_base & '0;
`endif

  int j;

  // Walk from lowest to highest priority so the best candidate lands last.
  always_comb begin
    o_pick = '0;
    o_idx  = '0;
    j      = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(w_base) + k;
      if (j >= N) j = j - N;
      if (i_req[j]) begin
        o_pick    = '0;
        o_pick[j] = 1'b1;
        o_idx     = IW'(j);
      end
    end
  end

endmodule

// File: rtl/ram_arb_n.sv
// N-port Wishbone-classic arbiter sharing one slave port between masters.
// RAM_ARB_RR_EN enables round-robin; otherwise lowest index has priority.
module ram_arb_n
  import ram_arb_n_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               wb_clk,
  input  logic               wb_rst,
  input  logic [N-1:0]       m_cyc,
  input  logic [N-1:0]       m_we,
  input  logic [4*N-1:0]     m_sel,
  input  logic [WIDTH*N-1:0] m_adr,
  input  logic [32*N-1:0]    m_dat,
  output logic [N-1:0]       m_ack,
  output logic [32*N-1:0]    m_rdt,
  output logic               x_cyc,
  output logic               x_we,
  output logic [3:0]         x_sel,
  output logic [WIDTH-1:0]   x_adr,
  output logic [31:0]        x_dat,
  input  logic               x_ack,
  input  logic [31:0]        x_rdt,
  output logic [N-1:0]       grant
);

  localparam int IW = idx_w(N);

  logic [N-1:0]  r_owner;
  logic [IW-1:0] r_last;

  logic          w_idle;
  logic [IW-1:0] w_base;
  logic [N-1:0]  w_pick;
  logic [IW-1:0] w_pick_idx;
  logic [N-1:0]  w_grant;

  assign w_idle = ~|r_owner;
  assign w_base = (r_last == IW'(N - 1)) ? '0 : r_last + IW'(1);

  ram_arb_n_rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .i_req  (m_cyc),
    .i_base (w_base),
    .o_pick (w_pick),
    .o_idx  (w_pick_idx)
  );

  // Idle grants combinationally so the first beat starts with no wait.
  assign w_grant = wb_rst ? '0 : (w_idle ? w_pick : r_owner);
  assign grant   = w_grant;

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      r_owner <= '0;
      r_last  <= IW'(N - 1);
    end else if (w_idle) begin
      r_owner <= w_pick;
      if (|w_pick) r_last <= w_pick_idx;
    end else if (~|(r_owner & m_cyc)) begin
      r_owner <= '0;
    end
  end

  always_comb begin
    x_cyc = 1'b0;
    x_we  = 1'b0;
    x_sel = '0;
    x_adr = '0;
    x_dat = '0;
    for (int i = 0; i < N; i++) begin
      x_cyc = x_cyc | (w_grant[i] & m_cyc[i]);
      x_we  = x_we  | (w_grant[i] & m_we[i]);
      x_sel = x_sel | (m_sel[4*i +: 4] & {4{w_grant[i]}});
      x_adr = x_adr | (m_adr[WIDTH*i +: WIDTH] & {WIDTH{w_grant[i]}});
      x_dat = x_dat | (m_dat[32*i +: 32] & {32{w_grant[i] & m_we[i]}});
    end
  end

  assign m_ack = w_grant & {N{x_ack}};

  always_comb begin
    m_rdt = '0;
    for (int i = 0; i < N; i++) begin
      m_rdt[32*i +: 32] = x_rdt & {32{w_grant[i] & x_ack & ~m_we[i]}};
    end
  end

endmodule

// File: tb/tb_ram_arb_n.sv
// Scoreboard bench for ram_arb_n (N=3); expectations follow RAM_ARB_RR_EN.
// Stimulus pushes expected acks; a negedge monitor pops and compares.
module tb_ram_arb_n;

  localparam int N = 3;
  localparam int W = 10;

  logic             wb_clk = 1'b0;
  logic             wb_rst;
  logic [N-1:0]     m_cyc;
  logic [N-1:0]     m_we;
  logic [4*N-1:0]   m_sel;
  logic [W*N-1:0]   m_adr;
  logic [32*N-1:0]  m_dat;
  logic [N-1:0]     m_ack;
  logic [32*N-1:0]  m_rdt;
  logic             x_cyc;
  logic             x_we;
  logic [3:0]       x_sel;
  logic [W-1:0]     x_adr;
  logic [31:0]      x_dat;
  logic             x_ack;
  logic [31:0]      x_rdt;
  logic [N-1:0]     grant;

  typedef struct {
    int              cyc;
    logic [N-1:0]    ack;
    logic [32*N-1:0] rdt;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  int   cyc_n = 0;
  logic zw    = 1'b0;
  logic s_ack = 1'b0;
  logic s_done = 1'b0;

  ram_arb_n #(.N(N), .WIDTH(W)) dut (
    .wb_clk (wb_clk),
    .wb_rst (wb_rst),
    .m_cyc  (m_cyc),
    .m_we   (m_we),
    .m_sel  (m_sel),
    .m_adr  (m_adr),
    .m_dat  (m_dat),
    .m_ack  (m_ack),
    .m_rdt  (m_rdt),
    .x_cyc  (x_cyc),
    .x_we   (x_we),
    .x_sel  (x_sel),
    .x_adr  (x_adr),
    .x_dat  (x_dat),
    .x_ack  (x_ack),
    .x_rdt  (x_rdt),
    .grant  (grant)
  );

  always #5 wb_clk = ~wb_clk;

  always @(posedge wb_clk) cyc_n <= cyc_n + 1;

  // Slave: one ack per frame, one cycle after cyc rises, or zero-wait.
  always @(posedge wb_clk) begin
    if (!x_cyc) begin
      s_ack  <= 1'b0;
      s_done <= 1'b0;
    end else if (s_ack) begin
      s_ack  <= 1'b0;
      s_done <= 1'b1;
    end else if (!s_done) begin
      s_ack <= 1'b1;
    end
  end

  assign x_ack = zw ? x_cyc : (s_ack & x_cyc);
  assign x_rdt = 32'hC0DE_0000 | {22'b0, x_adr};

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc_n);
    end
  endtask

  function automatic logic [32*N-1:0] rvec(input int p, input logic [W-1:0] a);
    logic [32*N-1:0] v;
    v = '0;
    v[32*p +: 32] = 32'hC0DE_0000 | {22'b0, a};
    return v;
  endfunction

  function automatic logic [N-1:0] oh(input int p);
    logic [N-1:0] v;
    v = '0;
    v[p] = 1'b1;
    return v;
  endfunction

  task automatic push(input int c, input logic [N-1:0] a,
                      input logic [32*N-1:0] r);
    exp_t e;
    e.cyc = c;
    e.ack = a;
    e.rdt = r;
    sb.push_back(e);
  endtask

  always @(negedge wb_clk) begin
    if (m_ack !== '0) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexp_ack: got %b want none (cycle %0d)", m_ack, cyc_n);
      end else begin
        mon_e = sb.pop_front();
        chk("ack_cycle", cyc_n, mon_e.cyc);
        chk("ack_vec", m_ack, mon_e.ack);
        chk("ack_rdt", m_rdt, mon_e.rdt);
        chk("ack_grant", grant, mon_e.ack);
      end
    end else begin
      chk("rdt_noack", m_rdt, 0);
    end
  end

  task automatic step();
    @(posedge wb_clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic we, input logic [3:0] sel,
                          input logic [W-1:0] adr, input logic [31:0] dat);
    m_we[p]            = we;
    m_sel[4*p +: 4]    = sel;
    m_adr[W*p +: W]    = adr;
    m_dat[32*p +: 32]  = dat;
  endtask

  task automatic reset_dut();
    wb_rst = 1'b1;
    m_cyc  = '0;
    step();
    step();
    wb_rst = 1'b0;
  endtask

  task automatic drain(input string nm);
    step();
    step();
    chk(nm, sb.size(), 0);
  endtask

  int t;
  int ord[4];
  int hold[N];
  int nack;
  logic [N-1:0] a;

  initial begin
    m_cyc = '0; m_we = '0; m_sel = '0; m_adr = '0; m_dat = '0;
    wb_rst = 1'b1;
    for (int p = 0; p < N; p++) set_port(p, 1'b1, 4'hF, W'(p + 1), 32'h1111_0000);
    step();
    m_cyc = '1;
    #1;
    chk("rst_xcyc", x_cyc, 0);
    chk("rst_grant", grant, 0);
    chk("rst_ack", m_ack, 0);
    chk("rst_xadr", x_adr, 0);
    chk("rst_xdat", x_dat, 0);

    // 1: single read, slave acks one cycle later
    reset_dut();
    set_port(0, 1'b0, 4'hF, W'('h010), 32'h0);
    m_cyc = 3'b001;
    #1;
    t = cyc_n;
    chk("t1_xcyc", x_cyc, 1);
    chk("t1_grant", grant, 3'b001);
    chk("t1_xadr", x_adr, 10'h010);
    push(t + 1, 3'b001, rvec(0, 10'h010));
    step();
    step();
    chk("t1_grant_hold", grant, 3'b001);
    m_cyc = '0;
    #1;
    chk("t1_rel_xcyc", x_cyc, 0);
    step();
    chk("t1_idle_grant", grant, 0);
    drain("t1_drain");

    // 2: all request from reset, each holds two cycles past ack
    reset_dut();
    for (int p = 0; p < N; p++) set_port(p, 1'b0, 4'hF, W'(32 + p), 32'h0);
`ifdef RAM_ARB_RR_EN
    ord = '{0, 1, 2, 0};
`else
    ord = '{0, 0, 0, 0};
`endif
    m_cyc = '1;
    #1;
    t = cyc_n;
    for (int k = 0; k < 4; k++)
      push(t + 1 + 5 * k, oh(ord[k]), rvec(ord[k], W'(32 + ord[k])));
    for (int p = 0; p < N; p++) hold[p] = -1;
    nack = 0;
    for (int c = 0; c < 30 && nack < 4; c++) begin
      @(negedge wb_clk);
      a = m_ack;
      step();
      for (int p = 0; p < N; p++) begin
        if (a[p]) begin
          hold[p] = 1;
          nack++;
        end else if (hold[p] > 0) begin
          hold[p]++;
        end
        if (hold[p] == 3) m_cyc[p] = 1'b0;
        else if (hold[p] == 4) begin
          m_cyc[p] = 1'b1;
          hold[p]  = -1;
        end
      end
    end
    m_cyc = '0;
    drain("t2_drain");

    // 3: owner 1 writes while port 0 waits
    reset_dut();
    set_port(0, 1'b0, 4'hF, W'('h0C3), 32'h1234_5678);
    set_port(1, 1'b1, 4'b0011, W'('h055), 32'hDEAD_BEEF);
    m_cyc = 3'b010;
    #1;
    t = cyc_n;
    chk("t3_grant1", grant, 3'b010);
    push(t + 1, 3'b010, '0);
    step();
    m_cyc = 3'b011;
    #1;
    chk("t3_grant_hold", grant, 3'b010);
    chk("t3_xdat", x_dat, 32'hDEAD_BEEF);
    chk("t3_xsel", x_sel, 4'b0011);
    chk("t3_xwe", x_we, 1);
    chk("t3_xadr", x_adr, 10'h055);
    step();
    step();
    m_cyc = 3'b001;
    #1;
    chk("t3_dead_xcyc", x_cyc, 0);
    step();
    chk("t3_grant0", grant, 3'b001);
    chk("t3_xcyc0", x_cyc, 1);
    chk("t3_xdat_rd", x_dat, 0);
    chk("t3_xsel0", x_sel, 4'hF);
    push(cyc_n + 1, 3'b001, rvec(0, 10'h0C3));
    step();
    step();
    m_cyc = '0;
    drain("t3_drain");

    // 4: zero-wait slave, ack in the start cycle
    reset_dut();
    zw = 1'b1;
    set_port(2, 1'b0, 4'hF, W'('h3FF), 32'h0);
    m_cyc = 3'b100;
    #1;
    t = cyc_n;
    push(t, 3'b100, rvec(2, 10'h3FF));
    step();
    m_cyc = '0;
    #1;
    chk("t4_rel_xcyc", x_cyc, 0);
    step();
    zw = 1'b0;
    drain("t4_drain");

    // 5: reset in the middle of port 2's transfer
    reset_dut();
    set_port(0, 1'b0, 4'hF, W'('h0C0), 32'h0);
    set_port(1, 1'b0, 4'hF, W'('h0C1), 32'h0);
    set_port(2, 1'b1, 4'hF, W'('h02A), 32'hCAFE_F00D);
    m_cyc = 3'b100;
    #1;
    chk("t5_grant2", grant, 3'b100);
    step();
    wb_rst = 1'b1;
    m_cyc  = 3'b111;
    #1;
    chk("t5_rst_xcyc", x_cyc, 0);
    chk("t5_rst_grant", grant, 0);
    chk("t5_rst_ack", m_ack, 0);
    chk("t5_rst_xdat", x_dat, 0);
    chk("t5_rst_xsel", x_sel, 0);
    step();
    wb_rst = 1'b0;
    #1;
    chk("t5_first_grant", grant, 3'b001);
    chk("t5_xadr", x_adr, 10'h0C0);
    push(cyc_n + 1, 3'b001, rvec(0, 10'h0C0));
    step();
    step();
    m_cyc = '0;
    drain("t5_drain");

    // 6: owner releases as port 1 requests on the same edge
    reset_dut();
    set_port(0, 1'b0, 4'hF, W'('h00A), 32'h0);
    set_port(1, 1'b0, 4'hF, W'('h00B), 32'h0);
    m_cyc = 3'b001;
    #1;
    t = cyc_n;
    push(t + 1, 3'b001, rvec(0, 10'h00A));
    step();
    step();
    m_cyc = 3'b010;
    #1;
    chk("t6_dead_xcyc", x_cyc, 0);
    chk("t6_dead_grant", grant, 3'b001);
    step();
    chk("t6_grant1", grant, 3'b010);
    chk("t6_xcyc1", x_cyc, 1);
    push(cyc_n + 1, 3'b010, rvec(1, 10'h00B));
    step();
    step();
    m_cyc = '0;
    drain("t6_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
